signed_digit_recompose: RTL and testbench

- Inverse of the gadget signed-digit decomposition used in the FHEW accumulator path.
- Accepts NUM_DIGITS signed base-2^LOG_B digits, most significant first, over a valid/ready stream.
- Rebuilds value = sum d_i * 2^(LOG_B*i) mod Q with a bit-serial Horner FSM: shift-double with conditional subtract, then signed add with reduction.
- Used on the readback/verification path to check decomposer output and to rebuild ring coefficients.

---
 rtl/signed_digit_recompose.sv | 116 +++++++++++
 tb/tb_signed_digit_recompose.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_digit_recompose.sv
// Rebuilds a mod-Q value from NUM_DIGITS signed base-2^LOG_B digits (MSB first)
// with a bit-serial Horner loop: LOG_B modular doublings, then one signed modular add.
module signed_digit_recompose #(
  parameter int              DATA_W     = 32,
  parameter int              LOG_B      = 7,
  parameter int              NUM_DIGITS = 4,
  parameter longint unsigned Q          = 134215681
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LOG_B-1:0]  digit_in,
  input  logic              digit_valid,
  output logic              digit_ready,
  output logic [DATA_W-1:0] value_out,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (LOG_B > 1) ? $clog2(LOG_B) : 1;
  localparam logic [DATA_W-1:0] QV       = DATA_W'(Q);
  localparam logic [CW-1:0]     LAST_DIG = CW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0]     LAST_SH  = SW'(LOG_B - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LOG_B-1:0]  dig_q, dig_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     sh_q, sh_d;
  logic [DATA_W-1:0] val_q, val_d;

  logic [DATA_W-1:0] dbl, sh_res, add_res;
  logic [DATA_W:0]   dig_x, sum;

  // acc < Q < 2^(DATA_W-1), so doubling never overflows and one subtract suffices
  always_comb begin
    dbl    = {acc_q[DATA_W-2:0], 1'b0};
    sh_res = (dbl >= QV) ? dbl - QV : dbl;
    dig_x  = {{(DATA_W + 1 - LOG_B){dig_q[LOG_B-1]}}, dig_q};
    sum    = {1'b0, acc_q} + dig_x;
    if (sum[DATA_W])
      add_res = sum[DATA_W-1:0] + QV;
    else if (sum[DATA_W-1:0] >= QV)
      add_res = sum[DATA_W-1:0] - QV;
    else
      add_res = sum[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    val_d   = val_q;
    case (state_q)
      S_IDLE: if (digit_valid) begin
        dig_d   = digit_in;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_ADD;
      end
      S_WAIT: if (digit_valid) begin
        dig_d   = digit_in;
        sh_d    = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        acc_d = sh_res;
        if (sh_q == LAST_SH) state_d = S_ADD;
        else                 sh_d    = sh_q + 1'b1;
      end
      S_ADD: begin
        acc_d = add_res;
        if (cnt_q == LAST_DIG) begin
          val_d   = add_res;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      val_q   <= val_d;
    end
  end

  assign digit_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign out_valid   = (state_q == S_DONE);
  assign value_out   = val_q;

endmodule

// File: tb/tb_signed_digit_recompose.sv
// Randomized bench for signed_digit_recompose against a sum-mod-Q reference.
module tb_signed_digit_recompose;
  localparam int     DATA_W = 32;
  localparam int     LOG_B  = 7;
  localparam int     ND     = 4;
  localparam longint Q      = 134215681;
  localparam int     LAT    = 1 + (ND - 1) * (LOG_B + 2);
  localparam int     PERIOD = LAT + 2;  // accept..DONE, one DONE cycle, one IDLE cycle

  typedef int dvec_t [ND];

  logic              clk = 0;
  logic              rst_n;
  logic [LOG_B-1:0]  digit_in;
  logic              digit_valid;
  logic              digit_ready;
  logic [DATA_W-1:0] value_out;
  logic              out_valid;
  logic              out_ready;

  signed_digit_recompose #(.DATA_W(DATA_W), .LOG_B(LOG_B), .NUM_DIGITS(ND), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .value_out(value_out), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int     tot = 0, bad = 0;
  longint exp_q[$];
  int     smode = 0;   // 0: ready high, 1: random, 2: hold low ~20 cycles in DONE
  bit     b2b = 0;
  int     ncyc = 0, last_rise = -1;
  bit     prev_ov = 0, prev_rdy = 0;
  logic [DATA_W-1:0] prev_val = '0;

  task automatic chk(input string nm, input longint act, input longint expv);
    tot++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Reference: the plain integer sum of d_i * B^i, reduced into [0, Q).
  function automatic longint gold(input dvec_t d);
    longint v = 0;
    for (int i = 0; i < ND; i++)
      v += longint'(d[i]) * (longint'(1) << (LOG_B * (ND - 1 - i)));
    v = v % Q;
    if (v < 0) v += Q;
    return v;
  endfunction

  function automatic int rnd_digit();
    int r = int'($urandom_range(0, 15));
    if (r == 0) return -64;
    if (r == 1) return 63;
    return int'($urandom_range(0, 127)) - 64;
  endfunction

  task automatic finish_all();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  endtask

  task automatic send_vec(input dvec_t d, input bit rnd, output longint t0);
    bit rdy, done;
    int tmo;
    t0 = 0;
    exp_q.push_back(gold(d));
    for (int i = 0; i < ND; i++) begin
      done = 0;
      tmo  = 0;
      while (!done) begin
        digit_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        digit_in    = digit_valid ? LOG_B'(d[i]) : LOG_B'($urandom);
        @(negedge clk);
        rdy = digit_ready;
        @(posedge clk);
        if (digit_valid && rdy) begin
          done = 1;
          if (i == 0) t0 = longint'($time);
        end
        #1;
        if (++tmo > 1000) begin
          chk("digit accept timeout", 0, 1);
          finish_all();
        end
      end
    end
    digit_valid = 0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain pending results", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic directed(input dvec_t d, input longint lit, input string nm);
    longint t0, tr;
    int w = 0;
    chk({nm, " model"}, gold(d), lit);
    send_vec(d, 0, t0);
    @(negedge clk);
    while (!out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " out_valid seen"}, out_valid, 1);
    tr = longint'($time) - 5;
    chk({nm, " latency"}, (tr - t0) / 10, LAT);
    chk({nm, " value"}, value_out, lit);
    drain();
  endtask

  // Sink: out_ready policy
  int hold = 0;
  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (!out_valid) hold = 0; else hold++;
      case (smode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (hold > 20);
      endcase
    end
  end

  // Compare process: every DONE cycle is checked; results compared when consumed.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 0;
      prev_rdy = 0;
    end else begin
      ncyc++;
      if (out_valid) begin
        chk("digit_ready low in DONE", digit_ready, 0);
        if (prev_ov && !prev_rdy) chk("value stable", value_out, prev_val);
        if (b2b) chk("single-cycle pulse", prev_ov, 0);
        if (!prev_ov) begin
          if (b2b && last_rise >= 0) chk("pulse spacing", ncyc - last_rise, PERIOD);
          last_rise = ncyc;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) chk("unexpected result", value_out, -1);
          else chk("result", value_out, exp_q.pop_front());
        end
      end
      prev_ov  = out_valid;
      prev_rdy = out_ready;
      prev_val = value_out;
    end
  end

  initial begin
    dvec_t  v;
    longint t0;
    rst_n = 0;
    digit_valid = 0;
    digit_in = '0;
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset value_out", value_out, 0);
    chk("reset digit_ready", digit_ready, 1);
    #21 rst_n = 1;
    @(posedge clk); #1;

    smode = 0;
    v = '{0, 0, 0, 5};     directed(v, 5, "d0005");
    v = '{1, 0, 0, 0};     directed(v, 2097152, "d1000");
    v = '{0, 0, 1, -64};   directed(v, 64, "d001m64");
    v = '{0, 0, 0, -1};    directed(v, 134215680, "d000m1");
    v = '{-64, 0, 0, 0};   directed(v, 134213634, "dm64000");
    v = '{63, 63, 63, 63}; directed(v, 133160895, "d63x4");

    // Async reset in the middle of SHIFT drops the partial value
    digit_valid = 1;
    digit_in = 7'd3;
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    digit_valid = 0;
    #1;
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset value_out", value_out, 0);
    chk("mid reset digit_ready", digit_ready, 1);
    #4 rst_n = 1;
    @(posedge clk); #1;
    v = '{0, 0, 0, 5};     directed(v, 5, "after reset");

    smode = 1;
    for (int n = 0; n < 700; n++) begin
      for (int i = 0; i < ND; i++) v[i] = rnd_digit();
      send_vec(v, 1, t0);
    end
    drain();

    smode = 2;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < ND; i++) v[i] = rnd_digit();
      send_vec(v, 1, t0);
    end
    drain();

    smode = 0;
    last_rise = -1;
    b2b = 1;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < ND; i++) v[i] = rnd_digit();
      send_vec(v, 0, t0);
    end
    drain();
    b2b = 0;

    finish_all();
  end
endmodule
